// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame capture block.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        DROP,
        HOLD
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the Ethernet CRC-32. Data bits enter LSB first, register kept MSB-aligned,
// so the good-frame residue is 0xC704DD7B rather than the bit-reversed 0xDEBB20E3.
module eth_crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    import eth_rx_pkg::*;

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_frame_capture.sv
// MII/GMII receive front end: preamble/SFD hunt, frame buffering until ack, status per frame.
// Optional FCS residue check is compiled in when ETH_RX_FCS_CHECK_EN is defined.
//
// state | meaning
// IDLE  | line quiet, waiting for rx_dv to rise
// PRE   | counting 0x55 preamble bytes, looking for SFD
// DATA  | storing frame body into the buffer
// DROP  | discarding the rest of a bad or unwanted frame until rx_dv falls
// HOLD  | frame held for software; new frames are counted as drops
module eth_rx_frame_capture #(
    parameter int IN_W      = 4,
    parameter int MAX_BYTES = 64,
    parameter int MIN_PRE   = 7,
    parameter int DROP_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_W-1:0]                rx_d,
    input  logic                           rx_dv,
    input  logic                           rx_er,
    input  logic [$clog2(MAX_BYTES)-1:0]   rd_addr,
    output logic [7:0]                     rd_data,
    output logic                           frame_valid,
    output logic [$clog2(MAX_BYTES+1)-1:0] frame_len,
    output logic                           frame_err,
    output logic                           crc_ok,
    input  logic                           frame_ack,
    output logic [DROP_W-1:0]              drop_cnt
);
    import eth_rx_pkg::*;

    localparam int AW    = $clog2(MAX_BYTES);
    localparam int LEN_W = $clog2(MAX_BYTES+1);
    localparam int PRE_W = $clog2(MIN_PRE+2);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BYTES);
    localparam logic [PRE_W-1:0] MIN_PRE_V = PRE_W'(MIN_PRE);
    localparam logic [AW:0]      RD_LIMIT  = (AW+1)'(MAX_BYTES);

    rx_state_e          state_q, state_d;
    logic               dv_q, rise;
    logic               byte_v, odd_nib;
    logic [7:0]         byte_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d, pre_cur;
    logic [LEN_W-1:0]   wr_ptr_q, frame_len_q;
    logic               err_q, ovf_q, frame_err_q;
    logic [DROP_W-1:0]  drop_cnt_q;
    logic               data_start, wr_en, ovf_set, hold_enter, drop_inc;
    logic [7:0]         mem [MAX_BYTES];

    assign rise = rx_dv & ~dv_q;

    // Byte assembly; odd_nib flags a lone low nibble waiting for its partner.
    if (IN_W == 8) begin : g_gmii
        assign byte_v  = rx_dv;
        assign byte_d  = rx_d;
        assign odd_nib = 1'b0;
    end else begin : g_mii
        logic       phase_q;
        logic [3:0] lo_q;

        always_ff @(posedge clk) begin
            if (rst || !rx_dv) phase_q <= 1'b0;
            else               phase_q <= ~phase_q;
            if (rx_dv && !phase_q) lo_q <= rx_d;
        end

        assign byte_v  = rx_dv & phase_q;
        assign byte_d  = {rx_d, lo_q};
        assign odd_nib = phase_q;
    end

    // In IDLE the rising beat already carries the first preamble byte (GMII), so it is judged here too.
    assign pre_cur = (state_q == IDLE) ? '0 : pre_cnt_q;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        data_start = 1'b0;
        wr_en      = 1'b0;
        ovf_set    = 1'b0;
        hold_enter = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            IDLE, PRE: begin
                if (state_q == PRE && !rx_dv) begin
                    state_d = IDLE;
                end else if (state_q == PRE || rise) begin
                    state_d   = PRE;
                    pre_cnt_d = pre_cur;
                    if (byte_v) begin
                        if (byte_d == PREAMBLE_BYTE) begin
                            if (pre_cur != '1) pre_cnt_d = pre_cur + 1'b1;
                        end else if (byte_d == SFD_BYTE && pre_cur >= MIN_PRE_V) begin
                            state_d    = DATA;
                            data_start = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_d    = HOLD;
                    hold_enter = 1'b1;
                end else if (byte_v) begin
                    if (wr_ptr_q == MAX_LEN) ovf_set = 1'b1;
                    else                     wr_en   = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) state_d = IDLE;
            end
            HOLD: begin
                drop_inc = rise;
                if (frame_ack) state_d = rx_dv ? DROP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dv_q        <= 1'b0;
            pre_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            frame_len_q <= '0;
            frame_err_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            dv_q      <= rx_dv;
            pre_cnt_q <= pre_cnt_d;
            if (data_start) begin
                wr_ptr_q <= '0;
                err_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (state_q == DATA && rx_dv) begin
                if (wr_en)   wr_ptr_q <= wr_ptr_q + 1'b1;
                if (ovf_set) ovf_q    <= 1'b1;
                if (rx_er)   err_q    <= 1'b1;
            end
            if (hold_enter) begin
                frame_len_q <= wr_ptr_q;
                frame_err_q <= err_q | ovf_q | odd_nib | (wr_ptr_q == '0);
            end
            if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= byte_d;
    end

    always_ff @(posedge clk) begin
        if (rst)                           rd_data <= '0;
        else if ({1'b0, rd_addr} < RD_LIMIT) rd_data <= mem[rd_addr];
        else                               rd_data <= '0;
    end

    assign frame_valid = (state_q == HOLD);
    assign frame_len   = frame_len_q;
    assign frame_err   = frame_err_q;
    assign drop_cnt    = drop_cnt_q;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_next;
    logic        crc_ok_q;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (byte_d),
        .crc_out (crc_next)
    );

    // Overflow bytes still feed the CRC; the overflow flag alone vetoes crc_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q    <= CRC_INIT;
            crc_ok_q <= 1'b0;
        end else begin
            if (data_start)           crc_q <= CRC_INIT;
            else if (wr_en || ovf_set) crc_q <= crc_next;
            if (hold_enter) crc_ok_q <= (crc_q == CRC_RESIDUE) && !ovf_q;
        end
    end

    assign crc_ok = crc_ok_q & frame_valid;
`else
    assign crc_ok = frame_valid;
`endif

endmodule

// File: tb/tb_eth_rx_frame_capture.sv
// Directed bench for eth_rx_frame_capture: an MII and a GMII instance driven from a vector table
// plus hand sequences for hold/drop counting, mid-frame reset, odd nibble and drop saturation.
module tb_eth_rx_frame_capture;

`ifdef ETH_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rx_d4 = '0;
    logic [7:0] rx_d8 = '0;
    logic       rx_dv4 = 1'b0, rx_dv8 = 1'b0, rx_er4 = 1'b0, rx_er8 = 1'b0;
    logic       ack4 = 1'b0, ack8 = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd4, rd8, dc4, dc8;
    logic [6:0] fl4, fl8;
    logic       fv4, fv8, fe4, fe8, ok4, ok8;

    always #5 clk = ~clk;

    eth_rx_frame_capture #(.IN_W(4)) dut4 (
        .clk(clk), .rst(rst), .rx_d(rx_d4), .rx_dv(rx_dv4), .rx_er(rx_er4),
        .rd_addr(rd_addr), .rd_data(rd4), .frame_valid(fv4), .frame_len(fl4),
        .frame_err(fe4), .crc_ok(ok4), .frame_ack(ack4), .drop_cnt(dc4));

    eth_rx_frame_capture #(.IN_W(8)) dut8 (
        .clk(clk), .rst(rst), .rx_d(rx_d8), .rx_dv(rx_dv8), .rx_er(rx_er8),
        .rd_addr(rd_addr), .rd_data(rd8), .frame_valid(fv8), .frame_len(fl8),
        .frame_err(fe8), .crc_ok(ok8), .frame_ack(ack8), .drop_cnt(dc8));

    bit         sel8 = 1'b0;
    logic       m_valid, m_err, m_crc;
    logic [6:0] m_len;
    logic [7:0] m_rd, m_drop;
    assign m_valid = sel8 ? fv8 : fv4;
    assign m_err   = sel8 ? fe8 : fe4;
    assign m_crc   = sel8 ? ok8 : ok4;
    assign m_len   = sel8 ? fl8 : fl4;
    assign m_rd    = sel8 ? rd8 : rd4;
    assign m_drop  = sel8 ? dc8 : dc4;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] fbuf [128];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Payload byte i = i+1+off; optional FCS computed with the reflected shift-right form.
    task automatic fill_body(input int payload, input bit fcs, input int off, output int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < payload; i++) begin
            fbuf[i] = 8'(i + 1 + off);
            c ^= {24'h0, fbuf[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        n = payload;
        if (fcs) begin
            c = ~c;
            for (int k = 0; k < 4; k++) fbuf[payload + k] = c[8*k +: 8];
            n = payload + 4;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic er);
        @(negedge clk);
        if (sel8) begin
            rx_dv8 = 1'b1; rx_d8 = b; rx_er8 = er;
        end else begin
            rx_dv4 = 1'b1; rx_d4 = b[3:0]; rx_er4 = er;
            @(negedge clk);
            rx_d4 = b[7:4];
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_dv4 = 1'b0; rx_er4 = 1'b0; rx_d4 = '0;
        rx_dv8 = 1'b0; rx_er8 = 1'b0; rx_d8 = '0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input int n_pre, input int n_body, input int er_at);
        for (int p = 0; p < n_pre; p++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < n_body; i++) drive_byte(fbuf[i], i == er_at);
        idle(2);
    endtask

    task automatic rd_check(input string nm, input int a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 6'(a);
        @(negedge clk);
        check(nm, m_rd, exp);
    endtask

    task automatic do_ack(input string nm);
        @(negedge clk);
        if (sel8) ack8 = 1'b1; else ack4 = 1'b1;
        @(negedge clk);
        ack4 = 1'b0; ack8 = 1'b0;
        check({nm, ".valid_after_ack"}, m_valid, 0);
    endtask

    typedef struct {
        string      name;
        bit         sel8;
        int         n_pre;
        int         payload;
        bit         fcs;
        int         er_at;
        bit         exp_valid;
        int         exp_len;
        bit         exp_err;
        bit         exp_crc;
        int         rd_a;
        logic [7:0] exp_rd;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int n;

        vecs[0] = '{"mii_good64",    1'b0, 7, 60, 1'b1, -1, 1'b1, 64, 1'b0, 1'b1,    0, 8'h01};
        vecs[1] = '{"mii_pre5",      1'b0, 5, 10, 1'b1, -1, 1'b0,  0, 1'b0, 1'b0,   -1, 8'h00};
        vecs[2] = '{"mii_rx_er",     1'b0, 7, 16, 1'b1, 10, 1'b1, 20, 1'b1, 1'b1,   10, 8'h0B};
        vecs[3] = '{"mii_ovf80",     1'b0, 7, 80, 1'b0, -1, 1'b1, 64, 1'b1, !FCS_EN, 63, 8'h40};
        vecs[4] = '{"gmii_good64",   1'b1, 7, 60, 1'b1, -1, 1'b1, 64, 1'b0, 1'b1,    0, 8'h01};
        vecs[5] = '{"mii_pre9",      1'b0, 9, 20, 1'b1, -1, 1'b1, 24, 1'b0, 1'b1,   19, 8'h14};
        vecs[6] = '{"mii_zero_len",  1'b0, 7,  0, 1'b0, -1, 1'b1,  0, 1'b1, !FCS_EN, -1, 8'h00};
        vecs[7] = '{"gmii_pre6",     1'b1, 6, 10, 1'b1, -1, 1'b0,  0, 1'b0, 1'b0,   -1, 8'h00};
        vecs[8] = '{"mii_ovf65",     1'b0, 7, 65, 1'b0, -1, 1'b1, 64, 1'b1, !FCS_EN, 63, 8'h40};
        vecs[9] = '{"gmii_exact64",  1'b1, 7, 64, 1'b0, -1, 1'b1, 64, 1'b0, !FCS_EN, 62, 8'h3F};

        repeat (3) @(negedge clk);
        check("reset.valid", fv4, 0);
        check("reset.len",   fl4, 0);
        check("reset.err",   fe4, 0);
        check("reset.crc",   ok4, 0);
        check("reset.drop",  dc4, 0);
        check("reset.rd",    rd4, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            sel8 = vecs[v].sel8;
            fill_body(vecs[v].payload, vecs[v].fcs, 0, n);
            send_frame(vecs[v].n_pre, n, vecs[v].er_at);
            check({vecs[v].name, ".valid"}, m_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) begin
                check({vecs[v].name, ".len"}, m_len, vecs[v].exp_len);
                check({vecs[v].name, ".err"}, m_err, vecs[v].exp_err);
                check({vecs[v].name, ".crc_ok"}, m_crc, vecs[v].exp_crc);
                if (vecs[v].rd_a >= 0) rd_check({vecs[v].name, ".rd"}, vecs[v].rd_a, vecs[v].exp_rd);
                do_ack(vecs[v].name);
            end
            check({vecs[v].name, ".drop"}, m_drop, 0);
        end

        // Frame held without ack: later frames only bump drop_cnt and leave buffer untouched.
        sel8 = 1'b0;
        fill_body(10, 1'b1, 0, n);
        send_frame(7, n, -1);
        check("hold.valid", m_valid, 1);
        check("hold.len", m_len, 14);
        for (int f = 0; f < 3; f++) begin
            fill_body(20, 1'b1, 8'h80, n);
            send_frame(7, n, -1);
        end
        check("hold.drop3", m_drop, 3);
        check("hold.len_kept", m_len, 14);
        check("hold.valid_kept", m_valid, 1);
        rd_check("hold.rd_kept", 0, 8'h01);
        do_ack("hold");
        fill_body(5, 1'b1, 8'h20, n);
        send_frame(7, n, -1);
        check("after_ack.valid", m_valid, 1);
        check("after_ack.len", m_len, 9);
        check("after_ack.err", m_err, 0);
        check("after_ack.crc", m_crc, 1);
        rd_check("after_ack.rd", 0, 8'h21);
        do_ack("after_ack");
        check("after_ack.drop", m_drop, 3);

        // Reset in the middle of DATA.
        fill_body(30, 1'b1, 0, n);
        for (int p = 0; p < 7; p++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive_byte(fbuf[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check("midrst.valid", fv4, 0);
        check("midrst.len",   fl4, 0);
        check("midrst.err",   fe4, 0);
        check("midrst.crc",   ok4, 0);
        check("midrst.drop",  dc4, 0);
        check("midrst.rd",    rd4, 0);
        rst = 1'b0;
        idle(2);
        check("midrst.no_frame", fv4, 0);
        send_frame(7, n, -1);
        check("postrst.valid", m_valid, 1);
        check("postrst.len", m_len, 34);
        check("postrst.err", m_err, 0);
        check("postrst.crc", m_crc, 1);
        rd_check("postrst.rd", 29, 8'h1E);
        do_ack("postrst");

        // Trailing lone nibble marks the frame bad; the partial byte is not stored.
        for (int p = 0; p < 7; p++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 5; i++) drive_byte(fbuf[i], 1'b0);
        @(negedge clk);
        rx_dv4 = 1'b1; rx_d4 = 4'hA;
        idle(2);
        check("oddnib.valid", m_valid, 1);
        check("oddnib.len", m_len, 5);
        check("oddnib.err", m_err, 1);
        do_ack("oddnib");

        // Drop counter saturation on the GMII instance.
        sel8 = 1'b1;
        fill_body(4, 1'b1, 0, n);
        send_frame(7, n, -1);
        check("sat.len", m_len, 8);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rx_dv8 = 1'b1; rx_d8 = 8'h55;
            @(negedge clk);
            rx_dv8 = 1'b0;
        end
        @(negedge clk);
        check("sat.drop", m_drop, 8'hFF);
        check("sat.valid", m_valid, 1);
        check("sat.len_kept", m_len, 8);
        do_ack("sat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
